// File: rtl/fifo_monitor.sv
// Passive checker that shadows an observed FIFO and compares its flags, data and error output.
// Keeps sticky first-failure status and saturating coverage counters.
module fifo_monitor #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int CNT_W     = 16,
    localparam int OW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              duv_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              empty,
    input  logic              almost_empty,
    input  logic              almost_full,
    input  logic              full,
    input  logic              error,
    output logic [OW-1:0]     occ,
    output logic              chk_err,
    output logic [3:0]        err_code,
    output logic [CNT_W-1:0]  cov_full,
    output logic [CNT_W-1:0]  cov_empty,
    output logic [CNT_W-1:0]  cov_ovf,
    output logic [CNT_W-1:0]  cov_udf,
    output logic [CNT_W-1:0]  cov_rst_full,
    output logic [CNT_W-1:0]  cov_rst_afull,
    output logic [CNT_W-1:0]  cov_rst_empty,
    output logic [CNT_W-1:0]  cov_rst_aempty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              err_exp_q, err_exp_d;
    logic              chk_q;
    logic [3:0]        code_q;
    logic [3:0]        fail_code;
    // hist bits: 0 full, 1 almost full, 2 empty, 3 almost empty
    logic [3:0]        hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q [8];
    logic [CNT_W-1:0]  cnt_d [8];
    logic [7:0]        inc;

    logic s_full, s_empty, s_afull, s_aempty;
    logic acc_push, acc_pop, ovf, udf, ovf_ev, udf_ev;

    assign s_full   = (occ_q == OW'(DEPTH));
    assign s_empty  = (occ_q == '0);
    assign s_afull  = (occ_q >= OW'(AFULL_TH));
    assign s_aempty = (occ_q <= OW'(AEMPTY_TH));

    // Push into a full shadow is still accepted when a pop frees the slot.
    assign acc_push = push & (~s_full | pop);
    assign acc_pop  = pop & ~s_empty;
    assign ovf      = push & s_full & ~pop;
    assign udf      = pop & s_empty;
    assign ovf_ev   = ovf & ~duv_reset;
    assign udf_ev   = udf & ~duv_reset;

    assign hist_d = {s_aempty, s_empty, s_afull, s_full};

    assign inc = {hist_q[3] & duv_reset,
                  hist_q[2] & duv_reset,
                  hist_q[1] & duv_reset,
                  hist_q[0] & duv_reset,
                  udf_ev,
                  ovf_ev,
                  s_empty & ~hist_q[2],
                  s_full & ~hist_q[0]};

    // Shadow pointer/occupancy update and pending-compare capture
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        pend_d    = 1'b0;
        exp_d     = exp_q;
        err_exp_d = 1'b0;
        if (duv_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (acc_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (acc_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                pend_d   = 1'b1;
                exp_d    = mem_q[rd_ptr_q];
            end
            if (acc_push && !acc_pop) begin
                occ_d = occ_q + OW'(1);
            end else if (!acc_push && acc_pop) begin
                occ_d = occ_q - OW'(1);
            end
            err_exp_d = ovf | udf;
        end
    end

    // Per-cycle checks; the first failing check in code order wins
    always_comb begin
        fail_code = 4'd0;
        if (!duv_reset) begin
            if (pend_q && (data_out != exp_q)) begin
                fail_code = 4'd1;
            end else if (empty != s_empty) begin
                fail_code = 4'd2;
            end else if (full != s_full) begin
                fail_code = 4'd3;
            end else if (almost_full != s_afull) begin
                fail_code = 4'd4;
            end else if (almost_empty != s_aempty) begin
                fail_code = 4'd5;
            end else if (err_exp_q && !error) begin
                fail_code = 4'd6;
            end else if (!err_exp_q && error) begin
                fail_code = 4'd7;
            end
        end
    end

    // Saturating increment of every coverage counter
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Shadow storage write (no reset needed, guarded by occupancy)
    always_ff @(posedge clk) begin
        if (!reset && !duv_reset && acc_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // State registers with synchronous monitor reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            pend_q    <= 1'b0;
            exp_q     <= '0;
            err_exp_q <= 1'b0;
            chk_q     <= 1'b0;
            code_q    <= 4'd0;
            hist_q    <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            pend_q    <= pend_d;
            exp_q     <= exp_d;
            err_exp_q <= err_exp_d;
            hist_q    <= hist_d;
            if (!chk_q && (fail_code != 4'd0)) begin
                chk_q  <= 1'b1;
                code_q <= fail_code;
            end
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign occ            = occ_q;
    assign chk_err        = chk_q;
    assign err_code       = code_q;
    assign cov_full       = cnt_q[0];
    assign cov_empty      = cnt_q[1];
    assign cov_ovf        = cnt_q[2];
    assign cov_udf        = cnt_q[3];
    assign cov_rst_full   = cnt_q[4];
    assign cov_rst_afull  = cnt_q[5];
    assign cov_rst_empty  = cnt_q[6];
    assign cov_rst_aempty = cnt_q[7];

endmodule

// File: tb/tb_fifo_monitor.sv
// Bench for fifo_monitor: directed vector table plus randomized traffic.
// The bench acts as the observed FIFO and keeps a queue-based reference.
module tb_fifo_monitor;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          duv_reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out = '0;
    logic          empty = 1'b1;
    logic          almost_empty = 1'b1;
    logic          almost_full = 1'b0;
    logic          full = 1'b0;
    logic          error = 1'b0;
    logic [4:0]    occ;
    logic          chk_err;
    logic [3:0]    err_code;
    logic [CW-1:0] cov_full, cov_empty, cov_ovf, cov_udf;
    logic [CW-1:0] cov_rst_full, cov_rst_afull;
    logic [CW-1:0] cov_rst_empty, cov_rst_aempty;

    fifo_monitor #(
        .DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFT),
        .AEMPTY_TH(AET), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .duv_reset(duv_reset),
        .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out),
        .empty(empty), .almost_empty(almost_empty),
        .almost_full(almost_full), .full(full), .error(error),
        .occ(occ), .chk_err(chk_err), .err_code(err_code),
        .cov_full(cov_full), .cov_empty(cov_empty),
        .cov_ovf(cov_ovf), .cov_udf(cov_udf),
        .cov_rst_full(cov_rst_full), .cov_rst_afull(cov_rst_afull),
        .cov_rst_empty(cov_rst_empty), .cov_rst_aempty(cov_rst_aempty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_pv = 0;
    logic [DW-1:0] m_pd = '0;
    bit            m_ee = 0;
    bit            m_chk = 0;
    int            m_code = 0;
    int            m_cnt[8];
    bit [3:0]      m_h = '0;   // 0 full, 1 afull, 2 empty, 3 aempty

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bump(input int i);
        if (m_cnt[i] < CMAX) m_cnt[i]++;
    endtask

    task automatic model_step();
        int n;
        int code;
        bit f, af, e, ae, ovf, udf;
        n = mq.size();
        code = 0;
        f = (n == DEPTH);
        af = (n >= AFT);
        e = (n == 0);
        ae = (n <= AET);
        if (reset) begin
            mq.delete();
            m_pv = 0; m_ee = 0; m_chk = 0; m_code = 0; m_h = '0;
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            return;
        end
        if (!duv_reset) begin
            if (m_pv && data_out != m_pd) code = 1;
            else if (empty != e) code = 2;
            else if (full != f) code = 3;
            else if (almost_full != af) code = 4;
            else if (almost_empty != ae) code = 5;
            else if (error != m_ee) code = m_ee ? 6 : 7;
        end
        if (f && !m_h[0]) bump(0);
        if (e && !m_h[2]) bump(1);
        if (duv_reset) begin
            if (m_h[0]) bump(4);
            if (m_h[1]) bump(5);
            if (m_h[2]) bump(6);
            if (m_h[3]) bump(7);
            mq.delete();
            m_pv = 0;
            m_ee = 0;
        end else begin
            ovf = push && f && !pop;
            udf = pop && e;
            if (ovf) bump(2);
            if (udf) bump(3);
            m_pv = pop && !e;
            if (m_pv) m_pd = mq.pop_front();
            if (push && (!f || pop)) mq.push_back(data_in);
            m_ee = ovf || udf;
        end
        if (!m_chk && code != 0) begin
            m_chk = 1;
            m_code = code;
        end
        m_h = {ae, e, af, f};
    endtask

    task automatic compare_all();
        check("occ", int'(occ), mq.size());
        check("chk_err", int'(chk_err), int'(m_chk));
        check("err_code", int'(err_code), m_code);
        check("cov_full", int'(cov_full), m_cnt[0]);
        check("cov_empty", int'(cov_empty), m_cnt[1]);
        check("cov_ovf", int'(cov_ovf), m_cnt[2]);
        check("cov_udf", int'(cov_udf), m_cnt[3]);
        check("cov_rst_full", int'(cov_rst_full), m_cnt[4]);
        check("cov_rst_afull", int'(cov_rst_afull), m_cnt[5]);
        check("cov_rst_empty", int'(cov_rst_empty), m_cnt[6]);
        check("cov_rst_aempty", int'(cov_rst_aempty), m_cnt[7]);
    endtask

    // flt: 0 none, 1 withhold error, 2 corrupt data_out,
    //      3 force full+almost_full, 4 spurious error
    task automatic do_cycle(input bit r, input bit dr, input bit pu,
                            input bit po, input int flt);
        int n;
        n = mq.size();
        reset = r;
        duv_reset = dr;
        push = pu;
        pop = po;
        data_in = $urandom();
        empty = (n == 0);
        full = (n == DEPTH);
        almost_full = (n >= AFT);
        almost_empty = (n <= AET);
        error = m_ee;
        data_out = m_pv ? m_pd : $urandom();
        case (flt)
            1: error = 1'b0;
            2: data_out = data_out ^ 32'h1;
            3: begin full = 1'b1; almost_full = 1'b1; end
            4: error = 1'b1;
            default: ;
        endcase
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        bit r; bit dr; bit pu; bit po; int n; int flt;
        int e_occ; int e_chk; int e_code;
        int e_cf; int e_ce; int e_co; int e_cra;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int pp;
        //           r  dr pu po n   flt occ chk code cf ce co cra
        tbl[0]  = '{1, 0, 0, 0, 2,  0,  0,  0,  0,  0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 16, 0,  16, 0,  0,  0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1,  0,  16, 0,  0,  1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 20, 0,  16, 0,  0,  1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 16, 0,  0,  0,  0,  1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1,  0,  0,  0,  0,  1, 2, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 16, 0,  16, 0,  0,  1, 2, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 1,  0,  16, 0,  0,  2, 2, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 1,  0,  16, 0,  0,  2, 2, 1, 0};
        tbl[9]  = '{0, 0, 1, 0, 1,  0,  16, 0,  0,  2, 2, 2, 0};
        tbl[10] = '{0, 0, 0, 0, 1,  1,  16, 1,  6,  2, 2, 2, 0};
        tbl[11] = '{1, 0, 0, 0, 1,  0,  0,  0,  0,  0, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 0, 5,  0,  5,  0,  0,  0, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 2,  0,  3,  0,  0,  0, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 1,  0,  2,  0,  0,  0, 1, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 1,  2,  2,  1,  1,  0, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 1,  4,  2,  1,  1,  0, 1, 0, 0};
        tbl[17] = '{1, 0, 0, 0, 1,  0,  0,  0,  0,  0, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 0, 15, 0,  15, 0,  0,  0, 1, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 1,  0,  0,  0,  0,  0, 1, 0, 1};
        tbl[20] = '{0, 0, 0, 0, 2,  0,  0,  0,  0,  0, 2, 0, 1};
        tbl[21] = '{0, 0, 1, 0, 3,  0,  3,  0,  0,  0, 2, 0, 1};
        tbl[22] = '{0, 0, 0, 0, 1,  3,  3,  1,  3,  0, 2, 0, 1};
        tbl[23] = '{1, 0, 1, 1, 1,  0,  0,  0,  0,  0, 0, 0, 0};

        for (int i = 0; i < 8; i++) m_cnt[i] = 0;

        for (int v = 0; v < 24; v++) begin
            for (int k = 0; k < tbl[v].n; k++)
                do_cycle(tbl[v].r, tbl[v].dr, tbl[v].pu,
                         tbl[v].po, tbl[v].flt);
            check($sformatf("row%0d occ", v), int'(occ), tbl[v].e_occ);
            check($sformatf("row%0d chk_err", v),
                  int'(chk_err), tbl[v].e_chk);
            check($sformatf("row%0d err_code", v),
                  int'(err_code), tbl[v].e_code);
            check($sformatf("row%0d cov_full", v),
                  int'(cov_full), tbl[v].e_cf);
            check($sformatf("row%0d cov_empty", v),
                  int'(cov_empty), tbl[v].e_ce);
            check($sformatf("row%0d cov_ovf", v),
                  int'(cov_ovf), tbl[v].e_co);
            check($sformatf("row%0d cov_rst_afull", v),
                  int'(cov_rst_afull), tbl[v].e_cra);
        end

        // Randomized traffic, alternating fill-biased and drain-biased
        // phases so that full, empty, overflow and underflow all occur.
        for (int i = 0; i < 4000; i++) begin
            bit r, dr, pu, po;
            int flt;
            pp = ((i / 120) % 2 == 0) ? 75 : 25;
            r = ($urandom_range(0, 699) == 0);
            dr = ($urandom_range(0, 79) == 0);
            pu = ($urandom_range(0, 99) < pp);
            po = ($urandom_range(0, 99) < (100 - pp));
            flt = ($urandom_range(0, 249) == 0) ?
                  int'($urandom_range(1, 4)) : 0;
            do_cycle(r, dr, pu, po, flt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
